// File: rtl/word_register.sv
// word_register: WIDTH-bit D register with synchronous active-high clear
//   clk   : rising-edge clock
//   reset : synchronous active-high; loads RESET_VALUE and overrides D and en
//   D     : data captured on each non-reset rising edge
//   Q     : registered data, one-cycle latency, no combinational path from D
//   en    : write enable, present only when REG_WRITE_ENABLE_EN is defined
module word_register #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef REG_WRITE_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  always_ff @(posedge clk)
    if (reset) Q <= RESET_VALUE;
`ifdef REG_WRITE_ENABLE_EN
    else if (en) Q <= D;
`else
    else Q <= D;
`endif
endmodule

// File: tb/tb_word_register.sv
// tb_word_register: directed self-checking bench for word_register
module tb_word_register;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] D;
  logic [63:0] Q;
  int          vectors = 0;
  int          miscompares = 0;
`ifdef REG_WRITE_ENABLE_EN
  logic        en;
`endif

  always #5 clk = ~clk;

  word_register #(.WIDTH(64), .RESET_VALUE(64'd0)) dut (
    .clk(clk),
    .reset(reset),
`ifdef REG_WRITE_ENABLE_EN
    .en(en),
`endif
    .D(D),
    .Q(Q)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef REG_WRITE_ENABLE_EN
    en = 1'b1;
`endif
    reset = 1'b1;
    D = 64'hDEAD_BEEF_0000_1111;
    edge_then_settle();
    check("reset_state", Q, 64'd0);
    reset = 1'b0;
    D = 64'd0;
    edge_then_settle();
    check("load_zero", Q, 64'd0);
    D = 64'd527;
    edge_then_settle();
    check("load_527", Q, 64'd527);
    D = -64'sd8;
    edge_then_settle();
    check("load_minus8", Q, 64'hFFFF_FFFF_FFFF_FFF8);
    D = 64'h3456_789A_BCDE_F012;
    edge_then_settle();
    check("load_wide", Q, 64'h3456_789A_BCDE_F012);
    D = 64'd77;
    edge_then_settle();
    check("load_77", Q, 64'd77);
    #1 D = 64'd4;
    #6 check("midcycle_d_hidden", Q, 64'd77);
    D = 64'd18;
    edge_then_settle();
    check("load_18", Q, 64'd18);
    #6 reset = 1'b1;
    #1 check("reset_before_edge", Q, 64'd18);
    edge_then_settle();
    check("reset_clears", Q, 64'd0);
    D = 64'd981;
    edge_then_settle();
    edge_then_settle();
    check("reset_held", Q, 64'd0);
    #4 reset = 1'b0;
    D = 64'd345;
    #1 check("deassert_before_edge", Q, 64'd0);
    edge_then_settle();
    check("first_load_after_reset", Q, 64'd345);
    D = 64'd981;
    edge_then_settle();
    check("load_981", Q, 64'd981);
`ifdef REG_WRITE_ENABLE_EN
    D = 64'd345;
    edge_then_settle();
    check("en_load_345", Q, 64'd345);
    en = 1'b0;
    D = 64'd7;
    edge_then_settle();
    edge_then_settle();
    check("en_low_holds", Q, 64'd345);
    en = 1'b1;
    edge_then_settle();
    check("en_high_loads", Q, 64'd7);
    en = 1'b0;
    reset = 1'b1;
    edge_then_settle();
    check("reset_overrides_en", Q, 64'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
